// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : RV32I decode/issue stage feeding the ALU. Accepts one
//             instruction+PC per handshake, reads rs1/rs2 combinationally,
//             decodes into the ALU control word and operands, and holds them
//             in a single ID/EX slot. Turns the ALU branch result of the
//             issued op into a PC redirect and squashes the wrong-path fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int XLEN       = 32,      // only 32 is supported
    parameter bit SHAMT_MASK = 1'b1     // 1: shift ops carry only shamt[4:0] in operand_B
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [5:0]      ALU_Control,
    output logic [XLEN-1:0] operand_A,
    output logic [XLEN-1:0] operand_B,
    output logic [4:0]      ex_rd,
    output logic            ex_wb_en,
    input  logic            alu_branch,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [1:0] c_CLASS_ARITH = 2'b00;
    localparam logic [1:0] c_CLASS_ALT   = 2'b01;
    localparam logic [1:0] c_CLASS_BR    = 2'b10;
    localparam logic [1:0] c_CLASS_JUMP  = 2'b11;

    // ID/EX slot
    logic            r_ex_valid;
    logic [5:0]      r_alu_ctrl;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [4:0]      r_rd;
    logic            r_wb_en;
    logic [XLEN-1:0] r_target;
    logic            r_illegal;

    // instruction fields
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd_field;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_is_shift;

    // decode results
    logic            w_legal;
    logic [1:0]      w_class;
    logic [2:0]      w_func;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_rd;
    logic            w_wb_en;
    logic [XLEN-1:0] w_target;

    logic            w_redirect;
    logic            w_accept;

    assign w_opcode   = in_instr[6:0];
    assign w_rd_field = in_instr[11:7];
    assign w_funct3   = in_instr[14:12];
    assign w_funct7   = in_instr[31:25];
    assign rs1_addr   = in_instr[19:15];
    assign rs2_addr   = in_instr[24:20];

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'd0};

    // pc+4 wraps naturally at the top of the address space
    assign w_pc_plus4 = in_pc + 32'd4;
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // A redirect is only taken once execute actually consumes the branch/jump,
    // and the instruction fetched alongside it is on the wrong path.
    assign w_redirect = r_ex_valid & ex_ready & r_alu_ctrl[4] & alu_branch;
    assign in_ready   = ~r_ex_valid | ex_ready;
    assign w_accept   = in_valid & in_ready & ~w_redirect;

    // Decode the presented instruction into ALU control, operands and branch target
    always_comb begin
        w_legal  = 1'b0;
        w_class  = c_CLASS_ARITH;
        w_func   = 3'b000;
        w_op_a   = '0;
        w_op_b   = '0;
        w_rd     = 5'd0;
        w_wb_en  = 1'b0;
        w_target = '0;
        case (w_opcode)
            c_OPC_OP: begin
                w_legal = 1'b1;
                w_class = ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))
                          ? c_CLASS_ALT : c_CLASS_ARITH;
                w_func  = w_funct3;
                w_op_a  = rs1_data;
                w_op_b  = (SHAMT_MASK && w_is_shift) ? {27'd0, rs2_data[4:0]} : rs2_data;
                w_rd    = w_rd_field;
                w_wb_en = (w_rd_field != 5'd0);
            end
            c_OPC_OPIMM: begin
                w_legal = 1'b1;
                w_class = ((w_funct7 == 7'h20) && (w_funct3 == 3'b101)) ? c_CLASS_ALT : c_CLASS_ARITH;
                w_func  = w_funct3;
                w_op_a  = rs1_data;
                // SLTIU also uses the sign-extended immediate; the ALU compares unsigned
                w_op_b  = (SHAMT_MASK && w_is_shift) ? {27'd0, in_instr[24:20]} : w_imm_i;
                w_rd    = w_rd_field;
                w_wb_en = (w_rd_field != 5'd0);
            end
            c_OPC_LUI: begin
                w_legal = 1'b1;
                w_op_b  = w_imm_u;
                w_rd    = w_rd_field;
                w_wb_en = (w_rd_field != 5'd0);
            end
            c_OPC_AUIPC: begin
                w_legal = 1'b1;
                w_op_a  = in_pc;
                w_op_b  = w_imm_u;
                w_rd    = w_rd_field;
                w_wb_en = (w_rd_field != 5'd0);
            end
            c_OPC_BRANCH: begin
                // funct3 010/011 are not branch conditions in RV32I
                if ((w_funct3 != 3'b010) && (w_funct3 != 3'b011)) begin
                    w_legal  = 1'b1;
                    w_class  = c_CLASS_BR;
                    w_func   = w_funct3;
                    w_op_a   = rs1_data;
                    w_op_b   = rs2_data;
                    w_target = in_pc + w_imm_b;
                end
            end
            c_OPC_JAL: begin
                w_legal  = 1'b1;
                w_class  = c_CLASS_JUMP;
                w_op_a   = w_pc_plus4;
                w_rd     = w_rd_field;
                w_wb_en  = (w_rd_field != 5'd0);
                w_target = in_pc + w_imm_j;
            end
            c_OPC_JALR: begin
                w_legal  = 1'b1;
                w_class  = c_CLASS_JUMP;
                w_op_a   = w_pc_plus4;
                w_rd     = w_rd_field;
                w_wb_en  = (w_rd_field != 5'd0);
                w_target = (rs1_data + w_imm_i) & ~32'd1;
            end
            default: ;
        endcase
    end

    // ID/EX slot: load on accept (illegal ops load as a bubble), empty when drained
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_valid <= 1'b0;
            r_alu_ctrl <= 6'd0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rd       <= 5'd0;
            r_wb_en    <= 1'b0;
            r_target   <= '0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ex_valid <= w_legal;
                r_alu_ctrl <= {1'b0, w_class, w_func};
                r_op_a     <= w_op_a;
                r_op_b     <= w_op_b;
                r_rd       <= w_rd;
                r_wb_en    <= w_wb_en;
                r_target   <= w_target;
                if (!w_legal) begin
                    r_illegal <= 1'b1;
                end
            end else if (ex_ready) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign ex_valid       = r_ex_valid;
    assign ALU_Control    = r_alu_ctrl;
    assign operand_A      = r_op_a;
    assign operand_B      = r_op_b;
    assign ex_rd          = r_rd;
    assign ex_wb_en       = r_wb_en;
    assign redirect_valid = w_redirect;
    assign redirect_pc    = r_target;
    assign illegal        = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Self-checking bench for alu_issue_stage. Instructions are built
//             from abstract fields; the expected slot contents are computed
//             from those fields and queued, and a monitor compares the DUT
//             outputs against the queue head every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam logic [3:0] K_OP = 4'd0, K_OPI = 4'd1, K_LUI = 4'd2, K_AUIPC = 4'd3,
                           K_BR = 4'd4, K_JAL = 4'd5, K_JALR = 4'd6, K_BAD = 4'd7;

    typedef struct packed {
        logic [3:0]  kind;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [6:0]  bad_op;
    } op_t;

    typedef struct packed {
        logic        legal;
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] target;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A, operand_B;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;
    logic        alu_branch;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal;

    logic [31:0] regs [32];
    exp_t        sb [$];
    logic        exp_illegal = 1'b0;
    logic        mon_en = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    always #5 clock = ~clock;

    alu_issue_stage #(.XLEN(32), .SHAMT_MASK(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ALU_Control(ALU_Control),
        .operand_A(operand_A), .operand_B(operand_B), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
        .alu_branch(alu_branch), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .illegal(illegal)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [3:0] kind, input logic [2:0] f3, input logic alt,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [6:0] bad_op);
        op_t o;
        o.kind = kind; o.f3 = f3; o.alt = alt; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
        o.imm = imm; o.bad_op = bad_op;
        return o;
    endfunction

    function automatic logic [31:0] encode(input op_t o);
        logic [6:0] f7;
        f7 = o.alt ? 7'h20 : 7'h00;
        case (o.kind)
            K_OP:    return {f7, o.rs2, o.rs1, o.f3, o.rd, 7'b0110011};
            K_OPI:   return (o.f3 == 3'd1 || o.f3 == 3'd5)
                            ? {f7, o.imm[4:0], o.rs1, o.f3, o.rd, 7'b0010011}
                            : {o.imm[11:0], o.rs1, o.f3, o.rd, 7'b0010011};
            K_LUI:   return {o.imm[19:0], o.rd, 7'b0110111};
            K_AUIPC: return {o.imm[19:0], o.rd, 7'b0010111};
            K_BR:    return {o.imm[12], o.imm[10:5], o.rs2, o.rs1, o.f3, o.imm[4:1], o.imm[11], 7'b1100011};
            K_JAL:   return {o.imm[20], o.imm[10:1], o.imm[11], o.imm[19:12], o.rd, 7'b1101111};
            K_JALR:  return {o.imm[11:0], o.rs1, 3'b000, o.rd, 7'b1100111};
            default: return {o.imm[11:0], o.rs1, o.f3, o.rd, o.bad_op};
        endcase
    endfunction

    // Expected slot contents straight from the instruction's meaning
    function automatic exp_t model(input op_t o, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic shift;
        e = '0;
        e.legal = 1'b1;
        e.rd = o.rd;
        e.wb = (o.rd != 5'd0);
        shift = (o.f3 == 3'd1) || (o.f3 == 3'd5);
        case (o.kind)
            K_OP: begin
                e.ctrl = {2'b00, (o.alt && (o.f3 == 3'd0 || o.f3 == 3'd5)), o.f3};
                e.a = r1;
                e.b = shift ? (r2 % 32) : r2;
            end
            K_OPI: begin
                e.ctrl = {2'b00, (o.alt && o.f3 == 3'd5), o.f3};
                e.a = r1;
                e.b = o.imm;
            end
            K_LUI:   e.b = o.imm << 12;
            K_AUIPC: begin e.a = pc; e.b = o.imm << 12; end
            K_BR: begin
                e.legal = !(o.f3 == 3'd2 || o.f3 == 3'd3);
                e.ctrl = {3'b010, o.f3};
                e.a = r1; e.b = r2; e.rd = 5'd0; e.wb = 1'b0;
                e.target = pc + o.imm;
            end
            K_JAL: begin
                e.ctrl = 6'b011000; e.a = pc + 32'd4; e.target = pc + o.imm;
            end
            K_JALR: begin
                e.ctrl = 6'b011000; e.a = pc + 32'd4; e.target = (r1 + o.imm) & 32'hFFFF_FFFE;
            end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

    // What a correct ALU would report as branch/jump outcome for the slot
    function automatic logic taken(input exp_t e);
        if (e.ctrl[4:3] == 2'b11) return 1'b1;
        case (e.ctrl[2:0])
            3'd0: return e.a == e.b;
            3'd1: return e.a != e.b;
            3'd4: return $signed(e.a) <  $signed(e.b);
            3'd5: return $signed(e.a) >= $signed(e.b);
            3'd6: return e.a <  e.b;
            3'd7: return e.a >= e.b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int unsigned r;
        o = '0;
        o.rd = 5'($urandom); o.rs1 = 5'($urandom); o.rs2 = 5'($urandom);
        o.f3 = 3'($urandom); o.alt = 1'($urandom);
        r = $urandom_range(0, 19);
        if (r <= 5) o.kind = K_OP;
        else if (r <= 10) o.kind = K_OPI;
        else if (r == 11) o.kind = K_LUI;
        else if (r == 12) o.kind = K_AUIPC;
        else if (r <= 15) o.kind = K_BR;
        else if (r == 16) o.kind = K_JAL;
        else if (r == 17) o.kind = K_JALR;
        else if (r == 18) o.kind = K_OPI;
        else o.kind = K_BAD;
        case (o.kind)
            K_OPI: begin
                if (o.f3 == 3'd1 || o.f3 == 3'd5) begin
                    o.imm = 32'($urandom_range(0, 31));
                    if (o.f3 == 3'd1) o.alt = 1'b0;
                end else o.imm = 32'($urandom_range(0, 4095) - 2048);
            end
            K_LUI, K_AUIPC: o.imm = 32'($urandom_range(0, 20'hFFFFF));
            K_BR:   o.imm = 32'(($urandom_range(0, 4095) - 2048) * 2);
            K_JAL:  o.imm = 32'(($urandom_range(0, 20'hFFFFF) - 32'h80000) * 2);
            K_JALR: o.imm = 32'($urandom_range(0, 4095) - 2048);
            K_BAD: begin
                r = $urandom_range(0, 3);
                o.bad_op = (r == 0) ? 7'b0000011 : (r == 1) ? 7'b0100011 :
                           (r == 2) ? 7'b0001111 : 7'b1110011;
                o.imm = 32'($urandom);
            end
            default: ;
        endcase
        return o;
    endfunction

    // One fetch cycle: drive inputs, decide acceptance from the model, then queue the result
    task automatic step(input op_t o, input logic v, input logic [31:0] pc,
                        input logic rdy, input logic rnd);
        logic has, redir, acc;
        exp_t e;
        @(negedge clock);
        if (rnd) for (int i = 0; i < 4; i++) regs[$urandom_range(1, 31)] = $urandom;
        in_instr = encode(o);
        in_pc    = pc;
        in_valid = v;
        ex_ready = rdy;
        has = (sb.size() != 0);
        alu_branch = has ? taken(sb[0]) : 1'($urandom);
        redir = has && rdy && sb[0].ctrl[4] && alu_branch;
        acc = v && (!has || rdy) && !redir;
        e = model(o, pc, regs[o.rs1], regs[o.rs2]);
        #1;
        if (v && (o.kind == K_OP || o.kind == K_OPI || o.kind == K_BR || o.kind == K_JALR))
            chk("rs1_addr", rs1_addr, o.rs1);
        if (v && (o.kind == K_OP || o.kind == K_BR))
            chk("rs2_addr", rs2_addr, o.rs2);
        @(posedge clock);
        if (acc) begin
            if (e.legal) sb.push_back(e);
            else exp_illegal = 1'b1;
        end
    endtask

    // Monitor: compare DUT against the queued slot, retire it when execute consumes it
    initial begin
        logic has, redir;
        forever begin
            @(negedge clock);
            #1;
            if (mon_en) begin
                has = (sb.size() != 0);
                chk("ex_valid", ex_valid, has);
                chk("in_ready", in_ready, !has || ex_ready);
                redir = has && ex_ready && sb[0].ctrl[4] && alu_branch;
                chk("redirect_valid", redirect_valid, redir);
                chk("illegal", illegal, exp_illegal);
                if (has) begin
                    chk("ALU_Control", ALU_Control, sb[0].ctrl);
                    chk("operand_A", operand_A, sb[0].a);
                    chk("operand_B", operand_B, sb[0].b);
                    chk("ex_rd", ex_rd, sb[0].rd);
                    chk("ex_wb_en", ex_wb_en, sb[0].wb);
                    if (redir) chk("redirect_pc", redirect_pc, sb[0].target);
                    if (ex_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        op_t nop;
        nop = mk(K_OP, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 7'd0);
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        ex_ready = 1'b0; alu_branch = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ALU_Control", ALU_Control, 0);
        chk("rst_operand_A", operand_A, 0);
        chk("rst_operand_B", operand_B, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_wb_en", ex_wb_en, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_illegal", illegal, 0);
        @(negedge clock);
        reset_n = 1'b1;
        mon_en = 1'b1;

        // ADD x3,x1,x2
        regs[1] = 32'd5; regs[2] = 32'd7;
        step(mk(K_OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 7'd0), 1'b1, 32'h0, 1'b1, 1'b0);
        #1;
        chk("add_ex_valid", ex_valid, 1);
        chk("add_ctrl", ALU_Control, 6'b000000);
        chk("add_A", operand_A, 5);
        chk("add_B", operand_B, 7);
        chk("add_rd", ex_rd, 3);
        chk("add_wb", ex_wb_en, 1);
        // SRAI x4,x1,3
        regs[1] = 32'h8000_0000;
        step(mk(K_OPI, 3'd5, 1'b1, 5'd4, 5'd1, 5'd0, 32'd3, 7'd0), 1'b1, 32'h4, 1'b1, 1'b0);
        #1;
        chk("srai_ctrl", ALU_Control, 6'b001101);
        chk("srai_A", operand_A, 32'h8000_0000);
        chk("srai_B", operand_B, 3);
        // SUB x5,x1,x2
        step(mk(K_OP, 3'd0, 1'b1, 5'd5, 5'd1, 5'd2, 32'd0, 7'd0), 1'b1, 32'h8, 1'b1, 1'b0);
        #1;
        chk("sub_ctrl", ALU_Control, 6'b001000);
        // SLL x6,x1,x2 with rs2 = 0x23
        regs[2] = 32'h23;
        step(mk(K_OP, 3'd1, 1'b0, 5'd6, 5'd1, 5'd2, 32'd0, 7'd0), 1'b1, 32'hC, 1'b1, 1'b0);
        #1;
        chk("sll_B", operand_B, 3);
        // BEQ taken at 0x100, imm -8; the following fetch is wrong-path
        regs[1] = 32'h55; regs[2] = 32'h55;
        step(mk(K_BR, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 7'd0), 1'b1, 32'h100, 1'b1, 1'b0);
        #1;
        chk("beq_rd", ex_rd, 0);
        step(mk(K_OP, 3'd0, 1'b0, 5'd7, 5'd1, 5'd2, 32'd0, 7'd0), 1'b1, 32'h104, 1'b1, 1'b0);
        #1;
        chk("beq_dropped", ex_valid, 0);
        // JALR at 0x200, rs1=0x1001, imm 2, execute stalls 3 cycles
        regs[1] = 32'h1001;
        step(mk(K_JALR, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2, 7'd0), 1'b1, 32'h200, 1'b0, 1'b0);
        #1;
        chk("jalr_A", operand_A, 32'h204);
        chk("jalr_class", ALU_Control[4:3], 2'b11);
        chk("jalr_target", redirect_pc, 32'h1002);
        repeat (3) step(nop, 1'b0, 32'h0, 1'b0, 1'b0);
        step(nop, 1'b0, 32'h0, 1'b1, 1'b0);
        // JAL at the top of the address space: link value wraps to 0
        step(mk(K_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 7'd0), 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        #1;
        chk("jal_wrap_A", operand_A, 0);
        chk("jal_target", redirect_pc, 32'hC);
        step(nop, 1'b0, 32'h0, 1'b1, 1'b0);
        // LW is unsupported: sticky illegal, no slot
        step(mk(K_BAD, 3'd2, 1'b0, 5'd8, 5'd1, 5'd0, 32'd0, 7'b0000011), 1'b1, 32'h300, 1'b1, 1'b0);
        #1;
        chk("lw_illegal", illegal, 1);
        chk("lw_no_valid", ex_valid, 0);

        // randomized traffic with random fetch-valid and execute back-pressure
        for (int n = 0; n < 400; n++)
            step(rand_op(), ($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 9) < 6), 1'b1);
        repeat (2) step(nop, 1'b0, 32'h0, 1'b1, 1'b0);

        // asynchronous reset in the middle of a stall
        step(mk(K_OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 7'd0), 1'b1, 32'h40, 1'b1, 1'b0);
        step(nop, 1'b0, 32'h0, 1'b0, 1'b0);
        mon_en = 1'b0;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ex_valid", ex_valid, 0);
        chk("arst_ctrl", ALU_Control, 0);
        chk("arst_A", operand_A, 0);
        chk("arst_B", operand_B, 0);
        chk("arst_rd", ex_rd, 0);
        chk("arst_wb", ex_wb_en, 0);
        chk("arst_illegal", illegal, 0);
        chk("arst_redirect_pc", redirect_pc, 0);
        sb.delete();
        exp_illegal = 1'b0;
        in_valid = 1'b0; ex_ready = 1'b1; alu_branch = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        mon_en = 1'b1;
        #2;
        chk("post_rst_no_redirect", redirect_valid, 0);
        step(nop, 1'b0, 32'h0, 1'b1, 1'b0);
        regs[1] = 32'd9; regs[2] = 32'd4;
        step(mk(K_OP, 3'd0, 1'b1, 5'd2, 5'd1, 5'd2, 32'd0, 7'd0), 1'b1, 32'h80, 1'b1, 1'b0);
        repeat (2) step(nop, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
